// File: rtl/battle_pkg.sv
// Shared codes for the battle turn sequencer: page codes,
// key codes, player opcodes, move directions and small helpers.
package battle_pkg;

  typedef enum logic [3:0] {
    PG_MENU   = 4'h1,
    PG_LOSE   = 4'h2,
    PG_WIN    = 4'h3,
    PG_DODGE  = 4'h9,
    PG_ATTACK = 4'hA,
    PG_ACTION = 4'hB
  } page_e;

  localparam logic [3:0] KEY_W     = 4'd1;
  localparam logic [3:0] KEY_A     = 4'd2;
  localparam logic [3:0] KEY_S     = 4'd3;
  localparam logic [3:0] KEY_D     = 4'd4;
  localparam logic [3:0] KEY_SPACE = 4'd8;

  localparam logic [3:0] OP_HPY = 4'd1;
  localparam logic [3:0] OP_DPY = 4'd2;
  localparam logic [3:0] OP_MOV = 4'd5;
  localparam logic [3:0] OP_SHP = 4'd6;

  localparam logic [7:0] DIR_UP    = 8'd0;
  localparam logic [7:0] DIR_LEFT  = 8'd1;
  localparam logic [7:0] DIR_DOWN  = 8'd2;
  localparam logic [7:0] DIR_RIGHT = 8'd3;

  localparam int TIMER_W = 8;

  function automatic logic [15:0] mk_instr(
    input logic [3:0] op,
    input logic [7:0] arg
  );
    return {op, arg, 4'h0};
  endfunction

  function automatic logic [7:0] sat_add(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase timer: counts tick strobes, sync clear, saturates at all-ones.
// Ports: clk, rst_n, clr_i, tick_i -> cnt_o.
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         tick_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // clear beats a simultaneous tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (clr_i)
      cnt_q <= '0;
    else if (tick_i && cnt_q != '1)
      cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/battle_sequencer.sv
// Turn sequencer MENU->DODGE->ACTION->ATTACK->..., WIN/LOSE end pages.
// Ports: tick/key/dmg/atk inputs; state, player_instr, target, mon_dmg, atk_* outputs.
module battle_sequencer
  import battle_pkg::*;
#(
  parameter int N_MON       = 2,
  parameter int MON_HP_MAX  = 100,
  parameter int PLAYER_HP   = 100,
  parameter int HEAL_AMT    = 10,
  parameter int MENU_HOLD   = 3,
  parameter int DODGE_TIME  = 7,
  parameter int ACTION_TIME = 5,
  parameter int ATK_TIME    = 4,
  parameter int END_TIME    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [3:0]         key,
  input  logic               is_death,
  input  logic               dmg_complete,
  input  logic [7:0]         damage,
  input  logic               heal,
  input  logic               atk_pass,
  input  logic [7:0]         dmg_mon,
  output logic [7:0]         state,
  output logic [15:0]        player_instr,
  output logic               is_move,
  output logic               start_dmg,
  output logic [1:0]         target,
  output logic [8*N_MON-1:0] mon_dmg,
  output logic               atk_start,
  output logic               atk_button,
  output logic               atk_reset
);

  page_e                   page_q, page_d;
  logic [15:0]             instr_q, instr_d;
  logic                    move_q, move_d;
  logic                    sdmg_q, sdmg_d;
  logic [1:0]              tgt_q, tgt_d;
  logic [N_MON-1:0][7:0]   dmg_q, dmg_d, hit;
  logic                    as_q, as_d;
  logic                    ab_q, ab_d;
  logic                    ar_q, ar_d;
  logic [3:0]              key_q;
  logic [TIMER_W-1:0]      timer;
  logic [N_MON-1:0]        live;
  logic                    sp, ka, kd, all_dead, clr;

  phase_timer #(.W(TIMER_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr),
    .tick_i(tick),
    .cnt_o (timer)
  );

  function automatic logic is_live(
    input logic [1:0]       cur,
    input logic [N_MON-1:0] lv
  );
    logic r;
    r = 1'b0;
    for (int m = 0; m < N_MON; m++)
      if (2'(m) == cur) r = lv[m];
    return r;
  endfunction

  // nearest live monster stepping up/down; k=N_MON is cur itself
  function automatic logic [1:0] seek(
    input logic [1:0]       cur,
    input logic             up,
    input logic [N_MON-1:0] lv
  );
    logic [1:0] r;
    int         c;
    r = cur;
    for (int k = N_MON; k >= 1; k--) begin
      c = up ? (int'(cur) + k) % N_MON
             : (int'(cur) + 2 * N_MON - k) % N_MON;
      for (int m = 0; m < N_MON; m++)
        if (m == c && lv[m]) r = 2'(m);
    end
    return r;
  endfunction

  always_comb begin
    sp = key == KEY_SPACE && key_q != KEY_SPACE;
    ka = key == KEY_A && key_q != KEY_A;
    kd = key == KEY_D && key_q != KEY_D;

    hit      = dmg_q;
    all_dead = 1'b1;
    for (int m = 0; m < N_MON; m++) begin
      live[m] = dmg_q[m] < 8'(MON_HP_MAX);
      if (2'(m) == tgt_q) hit[m] = sat_add(dmg_q[m], dmg_mon);
      if (hit[m] < 8'(MON_HP_MAX)) all_dead = 1'b0;
    end

    page_d  = page_q;
    instr_d = instr_q;
    move_d  = 1'b0;
    sdmg_d  = 1'b0;
    tgt_d   = tgt_q;
    dmg_d   = dmg_q;
    as_d    = as_q;
    ab_d    = ab_q;
    ar_d    = ar_q;

    unique case (page_q)
      PG_MENU: begin
        instr_d = '0;
        if (sp && timer >= TIMER_W'(MENU_HOLD)) begin
          page_d  = PG_DODGE;
          dmg_d   = '0;
          tgt_d   = '0;
          instr_d = mk_instr(OP_SHP, 8'(PLAYER_HP));
          ar_d    = 1'b1;
        end
      end
      PG_DODGE: begin
        instr_d = '0;
        if (is_death) begin
          page_d = PG_LOSE;
        end else if (timer >= TIMER_W'(DODGE_TIME)) begin
          page_d = PG_ACTION;
          if (!is_live(tgt_q, live))
            tgt_d = seek(tgt_q, 1'b1, live);
        end else if (dmg_complete) begin
          sdmg_d  = 1'b1;
          instr_d = heal ? mk_instr(OP_HPY, 8'(HEAL_AMT))
                         : mk_instr(OP_DPY, damage);
        end else begin
          unique case (key)
            KEY_W: begin
              instr_d = mk_instr(OP_MOV, DIR_UP);
              move_d  = 1'b1;
            end
            KEY_A: begin
              instr_d = mk_instr(OP_MOV, DIR_LEFT);
              move_d  = 1'b1;
            end
            KEY_S: begin
              instr_d = mk_instr(OP_MOV, DIR_DOWN);
              move_d  = 1'b1;
            end
            KEY_D: begin
              instr_d = mk_instr(OP_MOV, DIR_RIGHT);
              move_d  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      PG_ACTION: begin
        instr_d = '0;
        unique case (1'b1)
          ka:      tgt_d = seek(tgt_q, 1'b0, live);
          kd:      tgt_d = seek(tgt_q, 1'b1, live);
          default: ;
        endcase
        if (sp || timer >= TIMER_W'(ACTION_TIME)) begin
          page_d = PG_ATTACK;
          as_d   = 1'b1;
          ab_d   = 1'b0;
          ar_d   = 1'b0;
        end
      end
      PG_ATTACK: begin
        instr_d = '0;
        if (sp) ab_d = 1'b1;
        if (atk_pass) begin
          dmg_d  = hit;
          page_d = all_dead ? PG_WIN : PG_DODGE;
        end else if (timer >= TIMER_W'(ATK_TIME)) begin
          page_d = PG_DODGE;
        end
        if (page_d != PG_ATTACK) begin
          as_d = 1'b0;
          ab_d = 1'b0;
          ar_d = 1'b1;
        end
      end
      PG_WIN, PG_LOSE: begin
        instr_d = '0;
        if (timer >= TIMER_W'(END_TIME)) page_d = PG_MENU;
      end
      default: begin
        instr_d = '0;
        page_d  = PG_MENU;
      end
    endcase

    clr = page_d != page_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page_q  <= PG_MENU;
      instr_q <= '0;
      move_q  <= 1'b0;
      sdmg_q  <= 1'b0;
      tgt_q   <= '0;
      dmg_q   <= '0;
      as_q    <= 1'b0;
      ab_q    <= 1'b0;
      ar_q    <= 1'b1;
      key_q   <= '0;
    end else begin
      page_q  <= page_d;
      instr_q <= instr_d;
      move_q  <= move_d;
      sdmg_q  <= sdmg_d;
      tgt_q   <= tgt_d;
      dmg_q   <= dmg_d;
      as_q    <= as_d;
      ab_q    <= ab_d;
      ar_q    <= ar_d;
      key_q   <= key;
    end
  end

  assign state        = {page_q, 4'h0};
  assign player_instr = instr_q;
  assign is_move      = move_q;
  assign start_dmg    = sdmg_q;
  assign target       = tgt_q;
  assign mon_dmg      = dmg_q;
  assign atk_start    = as_q;
  assign atk_button   = ab_q;
  assign atk_reset    = ar_q;

endmodule

// File: tb/tb_battle_sequencer.sv
// Bench for battle_sequencer: directed table, hand sequences,
// then random play against a behavioural game model.
module tb_battle_sequencer;

  localparam int N     = 2;
  localparam int HPMAX = 100;
  localparam int PHP   = 100;
  localparam int HEAL  = 10;
  localparam int TMENU = 3;
  localparam int TDOD  = 7;
  localparam int TACT  = 5;
  localparam int TATK  = 4;
  localparam int TEND  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic [3:0]  key;
  logic        is_death;
  logic        dmg_complete;
  logic [7:0]  damage;
  logic        heal;
  logic        atk_pass;
  logic [7:0]  dmg_mon;
  logic [7:0]  state;
  logic [15:0] player_instr;
  logic        is_move;
  logic        start_dmg;
  logic [1:0]  target;
  logic [15:0] mon_dmg;
  logic        atk_start;
  logic        atk_button;
  logic        atk_reset;

  battle_sequencer #(.N_MON(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .key         (key),
    .is_death    (is_death),
    .dmg_complete(dmg_complete),
    .damage      (damage),
    .heal        (heal),
    .atk_pass    (atk_pass),
    .dmg_mon     (dmg_mon),
    .state       (state),
    .player_instr(player_instr),
    .is_move     (is_move),
    .start_dmg   (start_dmg),
    .target      (target),
    .mon_dmg     (mon_dmg),
    .atk_start   (atk_start),
    .atk_button  (atk_button),
    .atk_reset   (atk_reset)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  int nvec = 0;
  int nbad = 0;

  typedef struct packed {
    logic        tk;
    logic [3:0]  k;
    logic        dth;
    logic        dc;
    logic [7:0]  dmg;
    logic        hl;
    logic        ap;
    logic [7:0]  dm;
    logic [46:0] ex;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [46:0] E(
    input logic [7:0] st, input logic [15:0] ins,
    input logic mv, input logic sd, input logic [1:0] tg,
    input logic [2:0] atk, input logic [15:0] md);
    return {st, ins, mv, sd, tg, atk, md};
  endfunction

  function automatic logic [46:0] dut_out();
    return {state, player_instr, is_move, start_dmg, target,
            atk_start, atk_button, atk_reset, mon_dmg};
  endfunction

  task automatic add(
    input logic tk, input logic [3:0] k, input logic dth,
    input logic dc, input logic [7:0] dmg, input logic hl,
    input logic ap, input logic [7:0] dm, input logic [46:0] ex);
    vec_t v;
    v.tk = tk; v.k = k; v.dth = dth; v.dc = dc; v.dmg = dmg;
    v.hl = hl; v.ap = ap; v.dm = dm; v.ex = ex;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input int idx,
    input logic [46:0] got, input logic [46:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s #%0d got=%h want=%h", nm, idx, got, exp);
    end
  endtask

  task automatic drive(input logic tk, input logic [3:0] k,
    input logic dth, input logic dc, input logic [7:0] dmg,
    input logic hl, input logic ap, input logic [7:0] dm);
    tick = tk; key = k; is_death = dth; dmg_complete = dc;
    damage = dmg; heal = hl; atk_pass = ap; dmg_mon = dm;
  endtask

  task automatic cyc(input logic tk, input logic [3:0] k,
    input logic dth);
    drive(tk, k, dth, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
  endtask

  // ---------------- behavioural game model ----------------
  int m_pg, m_tm, m_pk, m_ins, m_tg;
  bit m_mv, m_sd, m_as, m_ab, m_ar;
  int m_hp[N];

  task automatic m_reset();
    m_pg = 1; m_tm = 0; m_pk = 0; m_ins = 0; m_tg = 0;
    m_mv = 0; m_sd = 0; m_as = 0; m_ab = 0; m_ar = 1;
    foreach (m_hp[i]) m_hp[i] = 0;
  endtask

  function automatic bit m_dead(int i);
    return m_hp[i] >= HPMAX;
  endfunction

  function automatic int m_seek(int dir);
    for (int s = 1; s <= N; s++) begin
      int c;
      c = (m_tg + dir * s + 2 * N) % N;
      if (!m_dead(c)) return c;
    end
    return m_tg;
  endfunction

  task automatic m_step(bit tk, int k, bit dth, bit dc,
    int dmg, bit hl, bit ap, int dm);
    bit sp;
    int np;
    bit all;
    sp = (k == 8) && (m_pk != 8);
    np = m_pg; m_mv = 0; m_sd = 0;
    case (m_pg)
      1: begin
        m_ins = 0;
        if (sp && m_tm >= TMENU) begin
          np = 9; m_tg = 0; m_ar = 1;
          foreach (m_hp[i]) m_hp[i] = 0;
          m_ins = 6 * 4096 + PHP * 16;
        end
      end
      9: begin
        m_ins = 0;
        if (dth) np = 2;
        else if (m_tm >= TDOD) begin
          np = 11;
          for (int i = 0; i < N && m_dead(m_tg); i++)
            m_tg = (m_tg + 1) % N;
        end else if (dc) begin
          m_sd = 1;
          m_ins = hl ? 1 * 4096 + HEAL * 16 : 2 * 4096 + dmg * 16;
        end else if (k >= 1 && k <= 4) begin
          m_mv = 1;
          m_ins = 5 * 4096 + (k - 1) * 16;
        end
      end
      11: begin
        if (k == 2 && m_pk != 2) m_tg = m_seek(-1);
        else if (k == 4 && m_pk != 4) m_tg = m_seek(1);
        if (sp || m_tm >= TACT) begin
          np = 10; m_as = 1; m_ab = 0; m_ar = 0;
        end
      end
      10: begin
        if (sp) m_ab = 1;
        if (ap) begin
          m_hp[m_tg] = m_hp[m_tg] + dm > 255 ? 255 : m_hp[m_tg] + dm;
          all = 1;
          foreach (m_hp[i]) if (!m_dead(i)) all = 0;
          np = all ? 3 : 9;
        end else if (m_tm >= TATK) np = 9;
        if (np != 10) begin m_as = 0; m_ab = 0; m_ar = 1; end
      end
      default: begin
        m_ins = 0;
        if (m_tm >= TEND) np = 1;
      end
    endcase
    if (np != m_pg) m_tm = 0;
    else if (tk && m_tm < 255) m_tm++;
    m_pg = np; m_pk = k;
  endtask

  function automatic logic [46:0] m_out();
    return {8'(m_pg * 16), 16'(m_ins), m_mv, m_sd, 2'(m_tg),
            m_as, m_ab, m_ar, 8'(m_hp[1]), 8'(m_hp[0])};
  endfunction

  localparam logic [46:0] RST = {8'h10, 16'h0, 1'b0, 1'b0,
                                 2'd0, 3'b001, 16'h0};

  initial begin
    // ---- directed table (expected values worked by hand) ----
    add(1,0,0,0,0,0,0,0, E(8'h10,16'h0,0,0,0,3'b001,16'h0));
    add(1,0,0,0,0,0,0,0, E(8'h10,16'h0,0,0,0,3'b001,16'h0));
    add(0,8,0,0,0,0,0,0, E(8'h10,16'h0,0,0,0,3'b001,16'h0));
    add(1,0,0,0,0,0,0,0, E(8'h10,16'h0,0,0,0,3'b001,16'h0));
    add(0,8,0,0,0,0,0,0, E(8'h90,16'h6640,0,0,0,3'b001,16'h0));
    add(0,8,0,0,0,0,0,0, E(8'h90,16'h0,0,0,0,3'b001,16'h0));
    add(0,1,0,0,0,0,0,0, E(8'h90,16'h5000,1,0,0,3'b001,16'h0));
    add(0,4,0,0,0,0,0,0, E(8'h90,16'h5030,1,0,0,3'b001,16'h0));
    add(0,0,0,1,8'h0C,0,0,0, E(8'h90,16'h20C0,0,1,0,3'b001,16'h0));
    add(0,0,0,0,0,0,0,0, E(8'h90,16'h0,0,0,0,3'b001,16'h0));
    add(0,0,0,1,8'h55,1,0,0, E(8'h90,16'h10A0,0,1,0,3'b001,16'h0));
    add(0,1,0,1,8'h05,0,0,0, E(8'h90,16'h2050,0,1,0,3'b001,16'h0));
    repeat (7)
      add(1,0,0,0,0,0,0,0, E(8'h90,16'h0,0,0,0,3'b001,16'h0));
    add(0,0,0,0,0,0,0,0, E(8'hB0,16'h0,0,0,0,3'b001,16'h0));
    add(0,4,0,0,0,0,0,0, E(8'hB0,16'h0,0,0,1,3'b001,16'h0));
    add(0,4,0,0,0,0,0,0, E(8'hB0,16'h0,0,0,1,3'b001,16'h0));
    add(0,8,0,0,0,0,0,0, E(8'hA0,16'h0,0,0,1,3'b100,16'h0));
    add(0,8,0,0,0,0,0,0, E(8'hA0,16'h0,0,0,1,3'b100,16'h0));
    add(0,0,0,0,0,0,0,0, E(8'hA0,16'h0,0,0,1,3'b100,16'h0));
    add(0,8,0,0,0,0,0,0, E(8'hA0,16'h0,0,0,1,3'b110,16'h0));
    add(0,0,0,0,0,0,1,8'd60, E(8'h90,16'h0,0,0,1,3'b001,16'h3C00));
    repeat (7)
      add(1,0,0,0,0,0,0,0, E(8'h90,16'h0,0,0,1,3'b001,16'h3C00));
    add(0,0,0,0,0,0,0,0, E(8'hB0,16'h0,0,0,1,3'b001,16'h3C00));
    add(0,8,0,0,0,0,0,0, E(8'hA0,16'h0,0,0,1,3'b100,16'h3C00));
    add(0,0,0,0,0,0,1,8'd60, E(8'h90,16'h0,0,0,1,3'b001,16'h7800));
    repeat (7)
      add(1,0,0,0,0,0,0,0, E(8'h90,16'h0,0,0,1,3'b001,16'h7800));
    add(0,0,0,0,0,0,0,0, E(8'hB0,16'h0,0,0,0,3'b001,16'h7800));
    add(0,4,0,0,0,0,0,0, E(8'hB0,16'h0,0,0,0,3'b001,16'h7800));
    add(0,8,0,0,0,0,0,0, E(8'hA0,16'h0,0,0,0,3'b100,16'h7800));
    repeat (4)
      add(1,0,0,0,0,0,0,0, E(8'hA0,16'h0,0,0,0,3'b100,16'h7800));
    add(0,0,0,0,0,0,0,0, E(8'h90,16'h0,0,0,0,3'b001,16'h7800));
    repeat (7)
      add(1,0,0,0,0,0,0,0, E(8'h90,16'h0,0,0,0,3'b001,16'h7800));
    add(0,0,0,0,0,0,0,0, E(8'hB0,16'h0,0,0,0,3'b001,16'h7800));
    add(0,8,0,0,0,0,0,0, E(8'hA0,16'h0,0,0,0,3'b100,16'h7800));
    add(0,0,0,0,0,0,1,8'd200, E(8'h30,16'h0,0,0,0,3'b001,16'h78C8));
    add(1,8,1,1,8'h11,0,1,8'd5, E(8'h30,16'h0,0,0,0,3'b001,16'h78C8));
    add(1,0,0,0,0,0,0,0, E(8'h30,16'h0,0,0,0,3'b001,16'h78C8));
    add(1,0,0,0,0,0,0,0, E(8'h30,16'h0,0,0,0,3'b001,16'h78C8));
    add(0,0,0,0,0,0,0,0, E(8'h10,16'h0,0,0,0,3'b001,16'h78C8));

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset", 0, dut_out(), RST);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].tk, tbl[i].k, tbl[i].dth, tbl[i].dc,
            tbl[i].dmg, tbl[i].hl, tbl[i].ap, tbl[i].dm);
      @(posedge clk); #1;
      check("table", i, dut_out(), tbl[i].ex);
    end

    // ---- death on the 7th dodge tick, then LOSE timeout ----
    repeat (3) cyc(1, 0, 0);
    cyc(0, 8, 0);
    check("menu_start", 0, 47'(state), 47'(8'h90));
    repeat (6) cyc(1, 0, 0);
    cyc(1, 0, 1);
    check("death", 0, 47'(state), 47'(8'h20));
    repeat (3) cyc(1, 0, 1);
    check("lose_hold", 0, 47'(state), 47'(8'h20));
    cyc(0, 8, 0);
    check("lose_exit", 0, 47'(state), 47'(8'h10));

    // ---- async reset in the middle of an attack ----
    repeat (3) cyc(1, 0, 0);
    cyc(0, 8, 0);
    repeat (7) cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 8, 0);
    check("atk_enter", 0, 47'(state), 47'(8'hA0));
    drive(0, 0, 0, 0, 0, 0, 1, 8'd50);
    #2 rst_n = 1'b0;
    #1 check("async_rst", 0, dut_out(), RST);
    @(posedge clk); #1;
    check("rst_hold", 0, dut_out(), RST);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();

    // ---- random play against the model ----
    begin
      logic [3:0] k;
      k = 0;
      for (int n = 0; n < 4000; n++) begin
        bit tk, dth, dc, hl, ap;
        int dmg, dm;
        if ($urandom % 2 == 0) k = 4'($urandom % 10);
        tk  = ($urandom % 3) == 0;
        dth = ($urandom % 60) == 0;
        dc  = ($urandom % 4) == 0;
        hl  = ($urandom % 2) == 0;
        ap  = ($urandom % 5) == 0;
        dmg = $urandom % 256;
        dm  = ($urandom % 3 == 0) ? 255 : $urandom % 80;
        drive(tk, k, dth, dc, 8'(dmg), hl, ap, 8'(dm));
        @(posedge clk);
        m_step(tk, int'(k), dth, dc, dmg, hl, ap, dm);
        #1;
        check("random", n, dut_out(), m_out());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
